// File: rtl/fifo_mem_param_pkg.sv
// FIFO_param_pkg: shared default geometry for the parametrised FIFO.
package FIFO_param_pkg;
  localparam int FIFO_WIDTH = 32;
  localparam int FIFO_DEPTH = 32;
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);
endpackage

// File: rtl/fifo_mem_param_ptr_ctr.sv
// fifo_ptr_ctr: modulo-DEPTH pointer with increment enable and synchronous clear.
module fifo_ptr_ctr #(
  parameter int DEPTH = 32,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          clr,
  input  logic          inc,
  output logic [PW-1:0] ptr
);
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) ptr <= '0;
    else if (clr) ptr <= '0;
    else if (inc) ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
endmodule

// File: rtl/fifo_mem_param.sv
// fifo_mem_param: single-clock FIFO with registered read, level flags and sticky errors.
module fifo_mem_param
  import FIFO_param_pkg::*;
#(
  parameter int WIDTH  = FIFO_WIDTH,
  parameter int DEPTH  = FIFO_DEPTH,
  parameter int AF_LVL = DEPTH - 2,
  parameter int AE_LVL = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic             flush,
  input  logic             err_clr,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             wr_full_err,
  output logic             rd_empty_err
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic wr_ok, rd_ok, wr_rej, rd_rej;
  assign full         = count == CW'(DEPTH);
  assign empty        = count == '0;
  assign almost_full  = int'(count) >= AF_LVL;
  assign almost_empty = int'(count) <= AE_LVL;
  // a full FIFO still takes a write when a read frees a slot in the same cycle
  assign rd_ok  = rd_en && !flush && !empty;
  assign wr_ok  = wr_en && !flush && (!full || rd_ok);
  assign wr_rej = wr_en && !flush && !wr_ok;
  assign rd_rej = rd_en && !flush && empty;
  fifo_ptr_ctr #(.DEPTH(DEPTH)) u_wr_ptr (.CLK(CLK), .nRST(nRST), .clr(flush), .inc(wr_ok), .ptr(wr_ptr));
  fifo_ptr_ctr #(.DEPTH(DEPTH)) u_rd_ptr (.CLK(CLK), .nRST(nRST), .clr(flush), .inc(rd_ok), .ptr(rd_ptr));
  always_ff @(posedge CLK)
    if (wr_ok) mem[wr_ptr] <= wr_data;
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      count        <= '0;
      rd_data      <= '0;
      rd_valid     <= 1'b0;
      wr_full_err  <= 1'b0;
      rd_empty_err <= 1'b0;
    end else begin
      count        <= flush ? '0 :
                      (wr_ok && !rd_ok) ? count + 1'b1 :
                      (rd_ok && !wr_ok) ? count - 1'b1 : count;
      rd_data      <= rd_ok ? mem[rd_ptr] : rd_data;
      rd_valid     <= rd_ok;
      wr_full_err  <= wr_rej || (wr_full_err && !err_clr);
      rd_empty_err <= rd_rej || (rd_empty_err && !err_clr);
    end
endmodule

// File: tb/tb_fifo_mem_param.sv
// tb_fifo_mem_param: directed and random checks of fifo_mem_param against a queue model.
module tb_fifo_mem_param;
  localparam int W = 32, D = 8;
  logic CLK = 0, nRST = 0;
  logic wr_en = 0, rd_en = 0, flush = 0, err_clr = 0;
  logic [W-1:0] wr_data = '0, rd_data;
  logic rd_valid, full, empty, almost_full, almost_empty, wr_full_err, rd_empty_err;
  logic [3:0] count;
  logic [W-1:0] q[$];
  logic [W-1:0] m_data = '0;
  bit m_valid, m_werr, m_rerr;
  int checks = 0, errors = 0;

  fifo_mem_param #(.WIDTH(W), .DEPTH(D), .AF_LVL(6), .AE_LVL(2)) dut (
    .CLK(CLK), .nRST(nRST), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .flush(flush), .err_clr(err_clr), .rd_data(rd_data), .rd_valid(rd_valid),
    .count(count), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .wr_full_err(wr_full_err), .rd_empty_err(rd_empty_err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, ".count"}, 32'(count), q.size());
    chk({tag, ".full"}, 32'(full), 32'(q.size() == D));
    chk({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
    chk({tag, ".af"}, 32'(almost_full), 32'(q.size() >= 6));
    chk({tag, ".ae"}, 32'(almost_empty), 32'(q.size() <= 2));
    chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(m_valid));
    chk({tag, ".rd_data"}, rd_data, m_data);
    chk({tag, ".wr_full_err"}, 32'(wr_full_err), 32'(m_werr));
    chk({tag, ".rd_empty_err"}, 32'(rd_empty_err), 32'(m_rerr));
  endtask

  task automatic model_reset();
    q.delete();
    m_data = '0;
    m_valid = 0;
    m_werr = 0;
    m_rerr = 0;
  endtask

  task automatic cycle(string tag, bit w, logic [W-1:0] wd, bit r, bit f = 0, bit c = 0);
    bit ra, wa;
    wr_en = w; wr_data = wd; rd_en = r; flush = f; err_clr = c;
    @(posedge CLK);
    ra = r && !f && q.size() > 0;
    wa = w && !f && (q.size() < D || ra);
    m_werr = (w && !f && !wa) || (m_werr && !c);
    m_rerr = (r && !f && q.size() == 0) || (m_rerr && !c);
    m_valid = ra;
    if (f) q.delete();
    else begin
      if (ra) m_data = q.pop_front();
      if (wa) q.push_back(wd);
    end
    #1;
    wr_en = 0; rd_en = 0; flush = 0; err_clr = 0;
    check_all(tag);
  endtask

  initial begin
    model_reset();
    #3 check_all("reset");
    @(negedge CLK) nRST = 1;
    // in-order fill and drain with full/empty boundaries
    for (int i = 0; i < D; i++) cycle("fill", 1, 32'hA0 + i, 0);
    chk("full_after_8", 32'(full), 1);
    for (int i = 0; i < D; i++) cycle("drain", 0, '0, 1);
    chk("empty_after_8", 32'(empty), 1);
    chk("last_word", rd_data, 32'hA7);
    // overflow drop and sticky error
    for (int i = 0; i < D; i++) cycle("fill2", 1, 32'hB0 + i, 0);
    cycle("ovf", 1, 32'hDEAD, 0);
    cycle("ovf_hold", 0, '0, 0);
    chk("werr_held", 32'(wr_full_err), 1);
    cycle("werr_clr", 0, '0, 0, 0, 1);
    for (int i = 0; i < D; i++) cycle("ovf_drain", 0, '0, 1);
    // full with simultaneous read/write wraps both pointers
    for (int i = 0; i < D; i++) cycle("fill3", 1, 32'hC0 + i, 0);
    for (int i = 0; i < D; i++) cycle("rw_full", 1, 32'h55, 1);
    for (int i = 0; i < D; i++) cycle("rw_drain", 0, '0, 1);
    // empty with simultaneous read/write: no bypass
    cycle("rw_empty", 1, 32'h11, 1);
    chk("rw_empty_cnt", 32'(count), 1);
    cycle("rw_empty_rd", 0, '0, 1);
    chk("rw_empty_data", rd_data, 32'h11);
    // new error wins over err_clr in the same cycle
    cycle("err_race", 0, '0, 1, 0, 1);
    chk("err_race_flag", 32'(rd_empty_err), 1);
    cycle("err_clr2", 0, '0, 0, 0, 1);
    // flush at count 5 ignores write and leaves errors
    for (int i = 0; i < 5; i++) cycle("fill5", 1, 32'hD0 + i, 0);
    cycle("flush", 1, 32'hEE, 1, 1);
    chk("flush_cnt", 32'(count), 0);
    cycle("post_flush_rd", 0, '0, 1);
    // async reset mid-burst
    for (int i = 0; i < 4; i++) cycle("fill4", 1, 32'hF0 + i, 0);
    #2 nRST = 0;
    #1 model_reset();
    check_all("rst_mid");
    @(negedge CLK) nRST = 1;
    cycle("rst_rd", 0, '0, 1);
    chk("rst_rd_err", 32'(rd_empty_err), 1);
    // random traffic
    for (int i = 0; i < 400; i++)
      cycle("rand", $urandom_range(0, 99) < 55, $urandom, $urandom_range(0, 99) < 45,
            $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
